// File: rtl/pipelined_tree_multiplier.sv
// Pipelined WIDTH x WIDTH tree multiplier: AND-array partial products, carry-save
// reduction to two rows, Kogge-Stone prefix adder. Valid/ready on both sides with a
// sideband tag. One global stall (adv) freezes every stage together.
// Optional feature macro: MULT_SIGNED_EN selects two's complement (Baugh-Wooley)
// operands and product; undefined builds an unsigned-only multiplier.
module pipelined_tree_multiplier #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned PIPE_TREE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int unsigned P = 2 * WIDTH;
`ifdef MULT_SIGNED_EN
  localparam int unsigned NROWS = WIDTH + 1;
`else
  localparam int unsigned NROWS = WIDTH;
`endif
  localparam int unsigned LV = $clog2(P);

  // Row count left after s rounds of 3:2 compression starting from n0 rows.
  function automatic int unsigned rows_after(input int unsigned n0, input int unsigned s);
    int unsigned n;
    n = n0;
    for (int unsigned k = 0; k < s; k++) begin
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  logic             adv;
  logic             s1_v;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic [TAG_W-1:0] s1_tag;

  logic [WIDTH-1:0] pp_bits [WIDTH];
  logic [P-1:0]     red [NROWS+1][NROWS];
  logic [P-1:0]     tree_a;
  logic [P-1:0]     tree_b;

  logic             add_v;
  logic             mid_v;
  logic [P-1:0]     add_a;
  logic [P-1:0]     add_b;
  logic [TAG_W-1:0] add_tag;
  logic [P-1:0]     add_sum;

  logic [P-1:0]     pfx_g;
  logic [P-1:0]     pfx_p;
  logic [P-1:0]     nxt_g;
  logic [P-1:0]     nxt_p;
  logic [P-1:0]     half_sum;
  int unsigned      pfx_d;

  // Global stall: every stage advances together or holds together.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign busy     = s1_v | mid_v | out_valid;

  // S1: operand register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_tag <= '0;
    end else if (adv) begin
      s1_v   <= in_valid;
      s1_x   <= x;
      s1_y   <= y;
      s1_tag <= in_tag;
    end
  end

  // AND-array partial products; signed build inverts the mixed-MSB terms.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp_bits[i][j] = s1_x[j] & s1_y[i];
`ifdef MULT_SIGNED_EN
        if ((i == WIDTH - 1) != (j == WIDTH - 1)) pp_bits[i][j] = ~(s1_x[j] & s1_y[i]);
`endif
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign red[0][i] = {{WIDTH{1'b0}}, pp_bits[i]} << i;
  end

`ifdef MULT_SIGNED_EN
  // Baugh-Wooley correction constants at columns WIDTH and 2*WIDTH-1.
  assign red[0][WIDTH] = (P'(1) << WIDTH) | (P'(1) << (P - 1));
`endif

  // Carry-save reduction: each round compresses row triples with full adders.
  for (genvar s = 0; s < NROWS; s++) begin : g_stage
    localparam int unsigned N  = rows_after(NROWS, s);
    localparam int unsigned NF = (N > 2) ? N / 3 : 0;
    localparam int unsigned NO = rows_after(NROWS, s + 1);
    for (genvar r = 0; r < NROWS; r++) begin : g_row
      if (r < NF) begin : g_fa
        logic [P-1:0] ra, rb, rc, maj;
        assign ra  = red[s][3*r];
        assign rb  = red[s][3*r+1];
        assign rc  = red[s][3*r+2];
        assign maj = (ra & rb) | (ra & rc) | (rb & rc);
        assign red[s+1][2*r]   = ra ^ rb ^ rc;
        assign red[s+1][2*r+1] = {maj[P-2:0], 1'b0};
      end
      if (r >= 3 * NF && r < N) begin : g_pass
        assign red[s+1][r - 3*NF + 2*NF] = red[s][r];
      end
      if (r >= NO) begin : g_zero
        assign red[s+1][r] = '0;
      end
    end
  end

  assign tree_a = red[NROWS][0];
  assign tree_b = red[NROWS][1];

  // Optional S2 register between the tree and the prefix adder.
  if (PIPE_TREE != 0) begin : g_pipe
    logic             s2_v;
    logic [P-1:0]     s2_a;
    logic [P-1:0]     s2_b;
    logic [TAG_W-1:0] s2_tag;

    // S2: two carry-save rows plus tag.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_v   <= 1'b0;
        s2_a   <= '0;
        s2_b   <= '0;
        s2_tag <= '0;
      end else if (adv) begin
        s2_v   <= s1_v;
        s2_a   <= tree_a;
        s2_b   <= tree_b;
        s2_tag <= s1_tag;
      end
    end

    assign add_v   = s2_v;
    assign add_a   = s2_a;
    assign add_b   = s2_b;
    assign add_tag = s2_tag;
    assign mid_v   = s2_v;
  end else begin : g_flow
    assign add_v   = s1_v;
    assign add_a   = tree_a;
    assign add_b   = tree_b;
    assign add_tag = s1_tag;
    assign mid_v   = 1'b0;
  end

  // Kogge-Stone prefix carries; nodes whose lower group already reaches bit 0
  // are grey cells (generate only), the rest are black cells.
  always_comb begin
    pfx_g    = add_a & add_b;
    pfx_p    = add_a ^ add_b;
    half_sum = pfx_p;
    nxt_g    = pfx_g;
    nxt_p    = pfx_p;
    pfx_d    = 1;
    for (int unsigned l = 0; l < LV; l++) begin
      pfx_d = 32'd1 << l;
      nxt_g = pfx_g;
      nxt_p = pfx_p;
      for (int unsigned i = 0; i < P; i++) begin
        if (i >= pfx_d) begin
          nxt_g[i] = pfx_g[i] | (pfx_p[i] & pfx_g[i - pfx_d]);
          if (i >= 2 * pfx_d) nxt_p[i] = pfx_p[i] & pfx_p[i - pfx_d];
        end
      end
      pfx_g = nxt_g;
      pfx_p = nxt_p;
    end
    add_sum = half_sum ^ {pfx_g[P-2:0], 1'b0};
  end

  // S3: product register driving the output port.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= add_v;
      o         <= add_sum;
      out_tag   <= add_tag;
    end
  end

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Directed bench for pipelined_tree_multiplier (WIDTH=8, TAG_W=4, PIPE_TREE=1).
// Expected values follow MULT_SIGNED_EN when the bench is built with it.
module tb_pipelined_tree_multiplier;

  localparam int unsigned EXP_LAT = 3;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  tag;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] o;
    logic [3:0]  tag;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] o;
  logic [3:0]  out_tag;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  vec_t tbl [10];
  vec_t bp  [4];
  res_t exp_q [$];

  int          lat;
  bit          got;
  int          sent;
  int          rcv;
  bit          holding;
  logic [15:0] held_o;
  logic [3:0]  held_tag;
  int          seen;
  int          first_c;
  int          last_c;
  int          ghost;
  res_t        r;
  logic [15:0] model;

  pipelined_tree_multiplier #(.WIDTH(8), .TAG_W(4), .PIPE_TREE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [15:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa * sb);
`else
    return 16'({8'd0, a} * {8'd0, b});
`endif
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef MULT_SIGNED_EN
    tbl[0] = '{8'd13, 8'd11, 4'd5,  16'h008F};
    tbl[1] = '{8'hFF, 8'hFF, 4'd1,  16'h0001};
    tbl[2] = '{8'h00, 8'hFF, 4'd2,  16'h0000};
    tbl[3] = '{8'h01, 8'h01, 4'd3,  16'h0001};
    tbl[4] = '{8'h80, 8'h80, 4'd4,  16'h4000};
    tbl[5] = '{8'h80, 8'h7F, 4'd6,  16'hC080};
    tbl[6] = '{8'hAA, 8'h55, 4'd7,  16'hE372};
    tbl[7] = '{8'hFF, 8'h01, 4'd8,  16'hFFFF};
    tbl[8] = '{8'h12, 8'h34, 4'd9,  16'h03A8};
    tbl[9] = '{8'hF0, 8'h0F, 4'd10, 16'hFF10};
`else
    tbl[0] = '{8'd13, 8'd11, 4'd5,  16'h008F};
    tbl[1] = '{8'hFF, 8'hFF, 4'd1,  16'hFE01};
    tbl[2] = '{8'h00, 8'hFF, 4'd2,  16'h0000};
    tbl[3] = '{8'h01, 8'h01, 4'd3,  16'h0001};
    tbl[4] = '{8'h80, 8'h80, 4'd4,  16'h4000};
    tbl[5] = '{8'h80, 8'h7F, 4'd6,  16'h3F80};
    tbl[6] = '{8'hAA, 8'h55, 4'd7,  16'h3872};
    tbl[7] = '{8'hFF, 8'h01, 4'd8,  16'h00FF};
    tbl[8] = '{8'h12, 8'h34, 4'd9,  16'h03A8};
    tbl[9] = '{8'hF0, 8'h0F, 4'd10, 16'h0E10};
`endif
    bp[0] = '{8'd5,   8'd6,   4'd1, 16'h001E};
    bp[1] = '{8'd100, 8'd3,   4'd2, 16'h012C};
    bp[2] = '{8'h11,  8'h11,  4'd3, 16'h0121};
    bp[3] = '{8'h7E,  8'd2,   4'd4, 16'h00FC};

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_o", o, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_in_ready", in_ready, 1);

    // Isolated ops: latency, product and tag per table row.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; x = tbl[k].x; y = tbl[k].y; in_tag = tbl[k].tag;
      @(posedge clk);
      lat = 0; got = 1'b0;
      for (int c = 1; c <= 8 && !got; c++) begin
        @(negedge clk);
        in_valid = 1'b0; x = 8'hA5; y = 8'h5A; in_tag = 4'hF;
        if (out_valid) begin got = 1'b1; lat = c; end
      end
      chk($sformatf("vec%0d_latency", k), lat, EXP_LAT);
      chk($sformatf("vec%0d_o", k), o, tbl[k].exp);
      chk($sformatf("vec%0d_tag", k), out_tag, tbl[k].tag);
    end

    // Streaming: 16 back-to-back ops, out_ready held high.
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          in_valid = 1'b1; x = 8'(i); y = 8'(i + 1); in_tag = 4'(i);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        seen = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (out_valid) begin
            if (seen < 16) begin
              chk($sformatf("stream%0d_o", seen), o, 32'(seen * (seen + 1)));
              chk($sformatf("stream%0d_tag", seen), out_tag, 32'(seen));
            end
            if (first_c < 0) first_c = c;
            last_c = c;
            seen++;
          end
        end
        chk("stream_count", seen, 16);
        chk("stream_consecutive", last_c - first_c, 15);
      end
    join

    // Backpressure: out_ready low for 5 cycles while 4 ops are offered.
    sent = 0; rcv = 0; holding = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (sent < 4) begin
        in_valid = 1'b1; x = bp[sent].x; y = bp[sent].y; in_tag = bp[sent].tag;
      end else begin
        in_valid = 1'b0; x = 8'h3C; y = 8'hC3;
      end
      #1;
      if (c == 3 || c == 4) begin
        chk($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
        chk($sformatf("bp_busy_c%0d", c), busy, 1);
      end
      if (holding) begin
        chk($sformatf("bp_hold_o_c%0d", c), o, held_o);
        chk($sformatf("bp_hold_tag_c%0d", c), out_tag, held_tag);
      end
      holding = out_valid && !out_ready;
      held_o = o; held_tag = out_tag;
      if (out_valid && out_ready) begin
        if (rcv < 4) begin
          chk($sformatf("bp%0d_o", rcv), o, bp[rcv].exp);
          chk($sformatf("bp%0d_tag", rcv), out_tag, bp[rcv].tag);
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("bp_sent", sent, 4);
    chk("bp_received", rcv, 4);

    // Reset mid-flight: two ops in the pipe are discarded.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; x = 8'd9; y = 8'd9; in_tag = 4'hA;
    @(negedge clk);
    x = 8'd7; y = 8'd3; in_tag = 4'hB;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_o", o, 0);
    chk("midrst_out_tag", out_tag, 0);
    chk("midrst_in_ready", in_ready, 1);
    ghost = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      x = 8'($urandom); y = 8'($urandom); in_tag = 4'($urandom);
      if (out_valid) ghost++;
    end
    chk("midrst_no_ghost", ghost, 0);

    // Random traffic against the reference model.
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      in_valid  = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (c < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      x = 8'($urandom); y = 8'($urandom); in_tag = 4'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_out", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("rand_o", o, r.o);
          chk("rand_tag", out_tag, r.tag);
        end
      end
      if (in_valid && in_ready) begin
        model = ref_mul(x, y);
        exp_q.push_back('{model, in_tag});
      end
    end
    chk("rand_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
